// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared widths, reset vector and redirect-source encoding for the fetch buffer.
// The redirect select helper encodes the LS > EX > ID priority in one place.
package ifu_fetch_buffer_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        RedirNone = 2'd0,
        RedirId   = 2'd1,
        RedirEx   = 2'd2,
        RedirLs   = 2'd3
    } redir_src_e;

    // Oldest stage wins: its redirect supersedes anything younger stages computed.
    function automatic redir_src_e redir_select(input logic ls, input logic ie, input logic id);
        if (ls) begin
            return RedirLs;
        end else if (ie) begin
            return RedirEx;
        end else if (id) begin
            return RedirId;
        end
        return RedirNone;
    endfunction

endpackage

// File: rtl/ifu_fetch_buffer_fifo.sv
// Parameterised synchronous FIFO with flush; pointers carry one extra wrap bit.
// Used both for the issued-PC queue and for the {pc, inst} instruction queue.
module ifu_fetch_buffer_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne   = (AW+1)'(1);
    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        count   = wr_ptr_q - rd_ptr_q;
        empty   = (count == '0);
        full    = (count == DepthCnt);
        do_pop  = pop && !empty;
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Instruction-fetch front end: credit-limited pipelined fetch into a small FIFO,
// with LS/EX/ID redirects and dropping of responses that belong to a squashed path.
module ifu_fetch_buffer
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int unsigned     XLEN     = PC_W,
    parameter logic [XLEN-1:0] RESET_PC = ifu_fetch_buffer_pkg::RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_pc_jump,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic            ie_pc_jump,
    input  logic [XLEN-1:0] ie_pc_i,
    input  logic            ls_pc_jump,
    input  logic [XLEN-1:0] ls_pc_i,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DepthWide = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    redir_src_e      redir_src;
    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] redir_target;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            issue;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;

    logic [XLEN-1:0] rsp_pc;
    logic            pcq_full, pcq_empty;
    logic [CW-1:0]   pcq_count;
    logic            inst_full, inst_empty;
    logic [CW-1:0]   occupancy;

    always_comb begin
        redir_src = redir_select(ls_pc_jump, ie_pc_jump, id_pc_jump);
        redirect  = (redir_src != RedirNone);
        unique case (redir_src)
            RedirLs: target_raw = ls_pc_i;
            RedirEx: target_raw = ie_pc_i;
            RedirId: target_raw = id_pc_i;
            default: target_raw = '0;
        endcase
        redir_target = target_raw & ~XLEN'(3);
    end

    always_comb begin
        // Credits count both buffered entries and requests whose data is still coming.
        imem_req_valid = !rst && !redirect &&
                         (({1'b0, occupancy} + {1'b0, outstanding_q}) < DepthWide);
        imem_req_addr  = fetch_pc_q;
        issue          = imem_req_valid && imem_req_ready;

        rsp_keep = imem_rsp_valid && !redirect && (drop_cnt_q == '0);
        rsp_drop = imem_rsp_valid && !redirect && (drop_cnt_q != '0);

        if_valid = !rst && !inst_empty && !redirect;
        pop      = if_valid && id_ready;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            // Everything still in flight belongs to the squashed path.
            fetch_pc_d    = redir_target;
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_keep);
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    ifu_fetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .wdata (fetch_pc_q),
        .pop   (rsp_keep),
        .flush (redirect),
        .rdata (rsp_pc),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    ifu_fetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_inst_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .wdata ({rsp_pc, imem_rsp_data}),
        .pop   (pop),
        .flush (redirect),
        .rdata ({pc_o, inst_o}),
        .full  (inst_full),
        .empty (inst_empty),
        .count (occupancy)
    );

    // The PC queue mirrors the outstanding counter; any divergence is a credit bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (pcq_count == outstanding_q);
            assert (!(rsp_keep && pcq_empty));
            assert (!(issue && pcq_full));
            assert (!(rsp_keep && inst_full && !pop));
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Directed and randomized bench for ifu_fetch_buffer against a queue-based model
// of the fetch path, with a fixed-latency in-order instruction memory.
module tb_ifu_fetch_buffer;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_pc_jump = 1'b0, ie_pc_jump = 1'b0, ls_pc_jump = 1'b0;
    logic [31:0] id_pc_i = '0, ie_pc_i = '0, ls_pc_i = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] inst_o, pc_o;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;

    always #5 clk = ~clk;

    ifu_fetch_buffer #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_pc_jump     (id_pc_jump),
        .id_pc_i        (id_pc_i),
        .ie_pc_jump     (ie_pc_jump),
        .ie_pc_i        (ie_pc_i),
        .ls_pc_jump     (ls_pc_jump),
        .ls_pc_i        (ls_pc_i),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int mem_lat = 1;

    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    logic [31:0] m_pc;
    logic [63:0] m_fifo[$];
    logic [31:0] m_pcq[$];
    int          m_out;
    int          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {ls_pc_jump, ie_pc_jump, id_pc_jump} = 3'b000;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        rst    = 1'b0;
        m_pc   = RESET_PC;
        m_fifo.delete();
        m_pcq.delete();
        m_out  = 0;
        m_drop = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance memory and model.
    task automatic step(input logic idr, input logic rdy, input logic [2:0] jmp,
                        input logic [31:0] lt, input logic [31:0] it, input logic [31:0] dt);
        logic        redir, exp_ifv, exp_rqv;
        logic [31:0] tgt;
        logic [63:0] e;
        @(negedge clk);
        id_ready = idr;
        imem_req_ready = rdy;
        {ls_pc_jump, ie_pc_jump, id_pc_jump} = jmp;
        ls_pc_i = lt;
        ie_pc_i = it;
        id_pc_i = dt;
        if (mem_due_q.size() > 0 && mem_due_q[0] == cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr_q[0] ^ 32'hFFFF_FFFF;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        redir = |jmp;
        tgt = jmp[2] ? lt : (jmp[1] ? it : dt);
        tgt[1:0] = 2'b00;
        exp_ifv = !redir && (m_fifo.size() > 0);
        exp_rqv = !redir && (m_fifo.size() + m_out < DEPTH);
        check("if_valid", 32'(if_valid), 32'(exp_ifv));
        check("req_valid", 32'(imem_req_valid), 32'(exp_rqv));
        if (exp_rqv) check("req_addr", imem_req_addr, m_pc);
        if (exp_ifv) begin
            check("pc_o", pc_o, m_fifo[0][63:32]);
            check("inst_o", inst_o, m_fifo[0][31:0]);
        end

        if (imem_rsp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cycle + mem_lat);
        end

        if (redir) begin
            m_pc   = tgt;
            m_fifo.delete();
            m_pcq.delete();
            m_drop = m_drop + m_out - int'(imem_rsp_valid);
            m_out  = 0;
        end else begin
            if (exp_ifv && idr) void'(m_fifo.pop_front());
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    check("rsp_expected", 32'(m_pcq.size() != 0), 32'd1);
                    if (m_pcq.size() != 0) begin
                        e = {m_pcq.pop_front(), imem_rsp_data};
                        m_fifo.push_back(e);
                        m_out--;
                    end
                end
            end
            if (exp_rqv && rdy) begin
                m_pcq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end
        cycle++;
    endtask

    initial begin
        logic [2:0] jmp;

        // Streaming with a one-cycle memory.
        do_reset();
        mem_lat = 1;
        repeat (20) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // Decode stall: credits run out, then the stream resumes in order.
        repeat (10) step(1'b0, 1'b1, 3'b000, '0, '0, '0);
        repeat (10) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // Slow memory: redirect while two requests are in flight.
        mem_lat = 3;
        repeat (6) step(1'b1, 1'b1, 3'b000, '0, '0, '0);
        step(1'b1, 1'b1, 3'b001, '0, '0, 32'h8000_0100);
        repeat (12) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // All three stages redirect together; LS must win.
        step(1'b1, 1'b1, 3'b111, 32'h8000_0200, 32'h8000_0300, 32'h8000_0400);
        repeat (10) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // Unaligned redirect target on a fast memory, overlapping response and pop.
        do_reset();
        mem_lat = 1;
        repeat (5) step(1'b1, 1'b1, 3'b000, '0, '0, '0);
        step(1'b1, 1'b1, 3'b001, '0, '0, 32'h8000_0013);
        repeat (6) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // Fill the FIFO, then reset mid-stream.
        repeat (8) step(1'b0, 1'b1, 3'b000, '0, '0, '0);
        do_reset();
        repeat (6) step(1'b1, 1'b1, 3'b000, '0, '0, '0);

        // Randomized phases with back-pressure on both sides and random redirects.
        for (int ph = 0; ph < 6; ph++) begin
            do_reset();
            mem_lat = int'($urandom_range(1, 3));
            for (int c = 0; c < 500; c++) begin
                jmp = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, jmp,
                     32'h8000_0000 | ($urandom & 32'h0000_0FFF),
                     32'h8000_0000 | ($urandom & 32'h0000_0FFF),
                     32'h8000_0000 | ($urandom & 32'h0000_0FFF));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
